// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern-detection controller.
// Contents: FSM state encoding, default parameter values, and the
// length-legality helper used by the configuration path.
package seq_det_pkg;

    localparam int unsigned PAT_MAX_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // A pattern length is usable only if it is 1..pat_max bits.
    function automatic logic len_legal(input int unsigned len, input int unsigned pat_max);
        return (len != 0) && (len <= pat_max);
    endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// Serial pattern matcher: history shift register, fill counter and masked
// compare against a programmable pattern of 1..PAT_MAX bits.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clr          - clear history and fill (start of a run)
//   x, x_valid   - serial bit and its qualifier (already gated to RUN)
//   pattern, len - pattern bits (pattern[len-1] is received first) and length
//   overlap      - 0: fill restarts after each match
//   match        - combinational: the sample presented this cycle completes a match
module seq_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_MAX = PAT_MAX_DEF,
    localparam int unsigned LEN_W  = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               x,
    input  logic               x_valid,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    logic [PAT_MAX-1:0] r_hist;
    logic [PAT_MAX-1:0] w_hist_nxt;
    logic [PAT_MAX-1:0] w_mask;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_nxt;

    // Post-update history and fill; match is judged on these values.
    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (x_valid) begin
            w_hist_nxt = {r_hist[PAT_MAX-2:0], x};
            w_fill_nxt = (r_fill < len) ? r_fill + LEN_W'(1) : len;
        end
    end

    // Low len bits of history/pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            w_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign match = x_valid && (w_fill_nxt == len) &&
                   ((w_hist_nxt & w_mask) == (pattern & w_mask));

    // History/fill registers; non-overlap mode restarts fill after a hit.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (x_valid) begin
            r_hist <= w_hist_nxt;
            r_fill <= (match && !overlap) ? '0 : w_fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller.
// Holds the shadow configuration, sequences IDLE -> RUN -> DONE, counts
// matches and produces a registered one-cycle match pulse.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cfg_we, cfg_*         - configuration write (accepted outside RUN)
//   start, stop           - begin / abort a run (stop wins)
//   x, x_valid            - serial data bit and qualifier
//   z                     - one-cycle match pulse (registered)
//   match_count           - saturating matches in current/last run
//   busy, done, cfg_err   - RUN state, target reached, illegal latched length
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_MAX = PAT_MAX_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    localparam int unsigned LEN_W  = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PAT_MAX-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic               r_cfg_err;

    logic [CNT_W-1:0]   r_count;
    logic               r_z;
    logic               r_busy;
    logic               r_done;

    logic               w_run;
    logic               w_cfg_accept;
    logic [LEN_W-1:0]   w_len_eff;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_xv_run;
    logic               w_match;
    logic               w_start_ok;
    logic               w_hit;
    logic               w_done_set;

    assign w_run        = (r_state == ST_RUN);
    assign w_cfg_accept = cfg_we && !w_run;
    // A write in the same cycle as start decides legality with the new length.
    assign w_len_eff    = w_cfg_accept ? cfg_len : r_len;
    assign w_count_inc  = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    assign w_xv_run     = x_valid && w_run;

    seq_pattern_matcher #(
        .PAT_MAX (PAT_MAX)
    ) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_start_ok),
        .x       (x),
        .x_valid (w_xv_run),
        .pattern (r_pattern),
        .len     (r_len),
        .overlap (r_overlap),
        .match   (w_match)
    );

    // Next state and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_hit       = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start && !stop && len_legal(32'(w_len_eff), PAT_MAX)) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_match) begin
                    w_hit = 1'b1;
                    if ((r_target != '0) && (w_count_inc == r_target)) begin
                        w_done_set  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, shadow config, counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_target  <= '0;
            r_cfg_err <= 1'b0;
            r_count   <= '0;
            r_z       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_z     <= w_hit;

            if (w_cfg_accept) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
                r_cfg_err <= !len_legal(32'(cfg_len), PAT_MAX);
            end

            if (w_start_ok) begin
                r_count <= '0;
                r_done  <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_count <= w_count_inc;
                end
                if (w_done_set) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign z           = r_z;
    assign match_count = r_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: vector table for the basic overlap/non-overlap
// runs, hand sequences for multi-cycle corners, then random traffic against
// a bit-queue reference model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_MAX = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = $clog2(PAT_MAX + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               x;
    logic               x_valid;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic               cfg_err;

    seq_det_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic               we;
        logic [PAT_MAX-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic [CNT_W-1:0]   tgt;
        logic               st;
        logic               sp;
        logic               xb;
        logic               xv;
        logic               ez;
        logic [CNT_W-1:0]   ecnt;
        logic               ebusy;
        logic               edone;
        logic               eerr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received bits kept in a queue, matched by slicing its tail.
    bit         m_run, m_done, m_err, m_z, m_ovl;
    int         m_cnt, m_len, m_tgt;
    logic [7:0] m_pat;
    bit         m_q[$];

    function automatic vec_t v_in(int rst, int we, int pat, int len, int ovl, int tgt,
                                  int st, int sp, int xb, int xv);
        vec_t v;
        v.rst = 1'(rst); v.we = 1'(we); v.pat = PAT_MAX'(pat); v.len = LEN_W'(len);
        v.ovl = 1'(ovl); v.tgt = CNT_W'(tgt); v.st = 1'(st); v.sp = 1'(sp);
        v.xb = 1'(xb); v.xv = 1'(xv);
        v.ez = 1'b0; v.ecnt = '0; v.ebusy = 1'b0; v.edone = 1'b0; v.eerr = 1'b0;
        return v;
    endfunction

    function automatic vec_t v_exp(vec_t vi, int ez, int ecnt, int eb, int ed, int ee);
        vec_t v = vi;
        v.ez = 1'(ez); v.ecnt = CNT_W'(ecnt); v.ebusy = 1'(eb); v.edone = 1'(ed); v.eerr = 1'(ee);
        return v;
    endfunction

    function automatic vec_t bitv(int xb, int xv);
        return v_in(0, 0, 0, 0, 0, 0, 0, 0, xb, xv);
    endfunction

    function automatic vec_t cfgv(int pat, int len, int ovl, int tgt, int st);
        return v_in(0, 1, pat, len, ovl, tgt, st, 0, 0, 0);
    endfunction

    function automatic vec_t ctlv(int st, int sp);
        return v_in(0, 0, 0, 0, 0, 0, st, sp, 0, 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input vec_t v);
        bit hit;
        m_z = 0;
        if (v.rst) begin
            m_run = 0; m_done = 0; m_err = 0; m_ovl = 0;
            m_cnt = 0; m_len = 0; m_tgt = 0; m_pat = '0;
            m_q.delete();
            return;
        end
        if (m_run) begin
            hit = 0;
            if (v.xv) begin
                m_q.push_back(v.xb);
                if (m_q.size() > PAT_MAX) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    hit = 1;
                    for (int i = 0; i < m_len; i++)
                        if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 0;
                end
            end
            if (v.sp) begin
                m_run = 0;
            end else if (hit) begin
                m_z = 1;
                if (m_cnt < 255) m_cnt++;
                if (!m_ovl) m_q.delete();
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else begin
            if (v.we) begin
                m_pat = v.pat; m_len = int'(v.len); m_ovl = v.ovl; m_tgt = int'(v.tgt);
                m_err = !(m_len >= 1 && m_len <= PAT_MAX);
            end
            if (v.st && !v.sp && m_len >= 1 && m_len <= PAT_MAX) begin
                m_run = 1; m_cnt = 0; m_done = 0;
                m_q.delete();
            end
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic apply(input vec_t v);
        reset = v.rst; cfg_we = v.we; cfg_pattern = v.pat; cfg_len = v.len;
        cfg_overlap = v.ovl; cfg_target = v.tgt; start = v.st; stop = v.sp;
        x = v.xb; x_valid = v.xv;
        @(posedge clk);
        #1;
        model_step(v);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".z"},     32'(z),           32'(m_z));
        check({tag, ".cnt"},   32'(match_count), 32'(m_cnt));
        check({tag, ".busy"},  32'(busy),        32'(m_run));
        check({tag, ".done"},  32'(done),        32'(m_done));
        check({tag, ".err"},   32'(cfg_err),     32'(m_err));
    endtask

    task automatic step(input string tag, input vec_t v);
        apply(v);
        cmp_model(tag);
    endtask

    vec_t tbl[$];

    initial begin : main
        bit s7 [7] = '{1, 0, 1, 1, 0, 1, 1};
        int z_ov [7] = '{0, 0, 0, 1, 0, 0, 1};
        int c_ov [7] = '{0, 0, 0, 1, 1, 1, 2};
        int z_no [7] = '{0, 0, 0, 1, 0, 0, 0};
        int c_no [7] = '{0, 0, 0, 1, 1, 1, 1};
        vec_t v;

        // Overlap run then non-overlap run of 1011 over 1,0,1,1,0,1,1.
        tbl.push_back(v_exp(v_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
        tbl.push_back(v_exp(cfgv(8'h0B, 4, 1, 0, 0), 0, 0, 0, 0, 0));
        tbl.push_back(v_exp(ctlv(1, 0), 0, 0, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(v_exp(bitv(int'(s7[i]), 1), z_ov[i], c_ov[i], 1, 0, 0));
        tbl.push_back(v_exp(bitv(1, 0), 0, 2, 1, 0, 0));
        tbl.push_back(v_exp(ctlv(0, 1), 0, 2, 0, 0, 0));
        tbl.push_back(v_exp(cfgv(8'h0B, 4, 0, 0, 0), 0, 2, 0, 0, 0));
        tbl.push_back(v_exp(ctlv(1, 0), 0, 0, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(v_exp(bitv(int'(s7[i]), 1), z_no[i], c_no[i], 1, 0, 0));
        tbl.push_back(v_exp(ctlv(0, 1), 0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            check($sformatf("tbl%0d.z", i),    32'(z),           32'(tbl[i].ez));
            check($sformatf("tbl%0d.cnt", i),  32'(match_count), 32'(tbl[i].ecnt));
            check($sformatf("tbl%0d.busy", i), 32'(busy),        32'(tbl[i].ebusy));
            check($sformatf("tbl%0d.done", i), 32'(done),        32'(tbl[i].edone));
            check($sformatf("tbl%0d.err", i),  32'(cfg_err),     32'(tbl[i].eerr));
        end

        // Target completion: pattern 11, target 3.
        step("t3cfg", cfgv(8'h03, 2, 1, 3, 0));
        step("t3st", ctlv(1, 0));
        for (int i = 0; i < 4; i++) step($sformatf("t3b%0d", i), bitv(1, 1));
        check("t3_done", 32'(done), 32'(1));
        check("t3_busy", 32'(busy), 32'(0));
        check("t3_cnt",  32'(match_count), 32'(3));
        step("t3post", bitv(1, 1));
        check("t3_post_z", 32'(z), 32'(0));

        // x_valid gaps inside a pattern.
        step("t4cfg", cfgv(8'h0B, 4, 1, 0, 0));
        step("t4st", ctlv(1, 0));
        check("t4_done_clr", 32'(done), 32'(0));
        step("t4b0", bitv(1, 1));
        for (int i = 0; i < 3; i++) step("t4gap", bitv(0, 0));
        step("t4b1", bitv(0, 1));
        step("t4b2", bitv(1, 1));
        step("t4b3", bitv(1, 1));
        check("t4_cnt", 32'(match_count), 32'(1));
        check("t4_z",   32'(z), 32'(1));

        // Config write during RUN is ignored.
        step("t5w", cfgv(8'h06, 4, 0, 1, 0));
        step("t5b0", bitv(1, 1));
        step("t5b1", bitv(0, 1));
        step("t5b2", bitv(1, 1));
        step("t5b3", bitv(1, 1));
        check("t5_old_pat", 32'(match_count), 32'(2));
        step("t5sp", ctlv(0, 1));
        // Illegal length, then start ignored.
        step("t5len0", cfgv(8'h0B, 0, 1, 0, 0));
        check("t5_err_set", 32'(cfg_err), 32'(1));
        step("t5st_bad", ctlv(1, 0));
        check("t5_busy_bad", 32'(busy), 32'(0));
        step("t5len9", cfgv(8'h0B, 9, 1, 0, 0));
        check("t5_err_len9", 32'(cfg_err), 32'(1));
        // Legal write clears cfg_err; start+stop stays idle.
        step("t5ok", cfgv(8'h0B, 4, 1, 0, 0));
        check("t5_err_clr", 32'(cfg_err), 32'(0));
        step("t5stsp", ctlv(1, 1));
        check("t5_stsp_busy", 32'(busy), 32'(0));
        // Write with start: legality from the incoming length.
        step("t5len0b", cfgv(8'h0B, 0, 1, 0, 0));
        step("t5wst", cfgv(8'h0B, 4, 1, 0, 1));
        check("t5_wst_busy", 32'(busy), 32'(1));
        step("t5sp2", ctlv(0, 1));

        // Reset mid-run after 3 of 4 bits.
        step("t6cfg", cfgv(8'h0B, 4, 1, 0, 0));
        step("t6st", ctlv(1, 0));
        step("t6b0", bitv(1, 1));
        step("t6b1", bitv(0, 1));
        step("t6b2", bitv(1, 1));
        step("t6rst", v_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        check("t6_rst_z",    32'(z),           32'(0));
        check("t6_rst_busy", 32'(busy),        32'(0));
        check("t6_rst_cnt",  32'(match_count), 32'(0));
        step("t6wst", cfgv(8'h0B, 4, 1, 0, 1));
        step("t6last", bitv(1, 1));
        check("t6_no_match", 32'(z), 32'(0));
        step("t6c0", bitv(1, 1));
        step("t6c1", bitv(0, 1));
        step("t6c2", bitv(1, 1));
        step("t6c3", bitv(1, 1));
        check("t6_full_z",   32'(z),           32'(1));
        check("t6_full_cnt", 32'(match_count), 32'(1));

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            v.rst = ($urandom_range(0, 199) == 0);
            v.we  = ($urandom_range(0, 9) == 0);
            v.pat = PAT_MAX'($urandom);
            v.len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9))
                                                : LEN_W'($urandom_range(1, 3));
            v.ovl = 1'($urandom_range(0, 1));
            v.tgt = CNT_W'($urandom_range(0, 5));
            v.st  = ($urandom_range(0, 7) == 0);
            v.sp  = ($urandom_range(0, 49) == 0);
            v.xb  = 1'($urandom_range(0, 1));
            v.xv  = ($urandom_range(0, 3) != 0);
            v.ez = 1'b0; v.ecnt = '0; v.ebusy = 1'b0; v.edone = 1'b0; v.eerr = 1'b0;
            step($sformatf("rnd%0d", n), v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
